// File: rtl/btb_update_ctrl_if.sv
// Branch-resolve update channel from EX into the BTB update controller.
// EX holds upd_* stable while upd_stall is high.
interface btb_update_ctrl_if;
  logic        upd_req;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_stall;

  modport master (
    output upd_req, upd_pc, upd_taken, upd_target,
    input  upd_stall
  );

  modport slave (
    input  upd_req, upd_pc, upd_taken, upd_target,
    output upd_stall
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-port owner: drains queued EX branch updates one per cycle and runs a
// full-table invalidate sweep on flush, blocking IF lookups while it runs.
module btb_update_ctrl #(
  parameter int unsigned BTB_INDEX_LEN = 12,
  parameter int unsigned QDEPTH        = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  btb_update_ctrl_if.slave             upd_if,
  input  logic                         flush_req_i,
  output logic                         flush_busy_o,
  output logic                         flush_done_o,
  output logic                         lookup_block_o,
  output logic                         btb_wr_en_o,
  output logic [BTB_INDEX_LEN-1:0]     btb_wr_index_o,
  output logic                         btb_wr_valid_o,
  output logic [31-BTB_INDEX_LEN:0]    btb_wr_tag_o,
  output logic [31:0]                  btb_wr_target_o,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count_o
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = $clog2(QDEPTH+1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e                   state_q;
  logic [BTB_INDEX_LEN-1:0] sweep_cnt_q;
  logic [PtrW-1:0]          wptr_q, rptr_q;
  logic [CntW-1:0]          count_q;
  logic [31:0]              pc_q     [QDEPTH];
  logic                     taken_q  [QDEPTH];
  logic [31:0]              target_q [QDEPTH];

  logic full, empty, push, pop;
  logic [31:0] head_pc;

  assign full    = (count_q == CntW'(QDEPTH));
  assign empty   = (count_q == '0);
  // Stall comes from the registered count only, so a same-cycle pop never frees a slot.
  assign push    = upd_if.upd_req & ~full;
  assign pop     = (state_q == StIdle) & ~empty;
  assign head_pc = pc_q[rptr_q];

  assign upd_if.upd_stall = full;
  assign q_count_o        = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sweep_cnt_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        pc_q[i]     <= '0;
        taken_q[i]  <= 1'b0;
        target_q[i] <= '0;
      end
    end else begin
      if (push) begin
        pc_q[wptr_q]     <= upd_if.upd_pc;
        taken_q[wptr_q]  <= upd_if.upd_taken;
        target_q[wptr_q] <= upd_if.upd_target;
      end
      unique case (state_q)
        StIdle: begin
          if (flush_req_i) begin
            // Queued and same-edge updates predate the flush and are dropped.
            state_q     <= StSweep;
            sweep_cnt_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
          end else begin
            wptr_q  <= wptr_q + PtrW'(push);
            rptr_q  <= rptr_q + PtrW'(pop);
            count_q <= count_q + CntW'(push) - CntW'(pop);
          end
        end
        StSweep: begin
          wptr_q  <= wptr_q + PtrW'(push);
          count_q <= count_q + CntW'(push);
          if (flush_req_i) begin
            sweep_cnt_q <= '0;
          end else begin
            sweep_cnt_q <= sweep_cnt_q + 1'b1;
            if (sweep_cnt_q == '1) state_q <= StDone;
          end
        end
        StDone: begin
          wptr_q      <= wptr_q + PtrW'(push);
          count_q     <= count_q + CntW'(push);
          sweep_cnt_q <= '0;
          state_q     <= flush_req_i ? StSweep : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    flush_busy_o    = 1'b0;
    flush_done_o    = 1'b0;
    lookup_block_o  = 1'b0;
    btb_wr_en_o     = 1'b0;
    btb_wr_index_o  = '0;
    btb_wr_valid_o  = 1'b0;
    btb_wr_tag_o    = '0;
    btb_wr_target_o = '0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          btb_wr_en_o     = 1'b1;
          btb_wr_index_o  = head_pc[BTB_INDEX_LEN-1:0];
          btb_wr_valid_o  = taken_q[rptr_q];
          btb_wr_tag_o    = head_pc[31:BTB_INDEX_LEN];
          btb_wr_target_o = target_q[rptr_q];
        end
      end
      StSweep: begin
        flush_busy_o   = 1'b1;
        lookup_block_o = 1'b1;
        btb_wr_en_o    = 1'b1;
        btb_wr_index_o = sweep_cnt_q;
      end
      StDone: begin
        flush_busy_o = 1'b1;
        flush_done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl with a 16-entry BTB and a 4-deep update FIFO.
module tb_btb_update_ctrl;

  localparam int unsigned IL = 4;
  localparam int unsigned QD = 4;

  typedef struct packed {
    logic [IL-1:0]   idx;
    logic            valid;
    logic [31-IL:0]  tag;
    logic [31:0]     tgt;
  } wr_t;

  logic clk, rst_n, flush_req;
  logic flush_busy, flush_done, lookup_block;
  logic btb_wr_en, btb_wr_valid;
  logic [IL-1:0]  btb_wr_index;
  logic [31-IL:0] btb_wr_tag;
  logic [31:0]    btb_wr_target;
  logic [$clog2(QD+1)-1:0] q_count;

  btb_update_ctrl_if u_if ();

  btb_update_ctrl #(.BTB_INDEX_LEN(IL), .QDEPTH(QD)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .upd_if         (u_if),
    .flush_req_i    (flush_req),
    .flush_busy_o   (flush_busy),
    .flush_done_o   (flush_done),
    .lookup_block_o (lookup_block),
    .btb_wr_en_o    (btb_wr_en),
    .btb_wr_index_o (btb_wr_index),
    .btb_wr_valid_o (btb_wr_valid),
    .btb_wr_tag_o   (btb_wr_tag),
    .btb_wr_target_o(btb_wr_target),
    .q_count_o      (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];

  logic [31:0]    v_pc  [8];
  logic           v_tk  [8];
  logic [31:0]    v_tgt [8];
  logic [IL-1:0]  v_idx [8];
  logic [31-IL:0] v_tag [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_upd(input int i);
    u_if.upd_req    = 1'b1;
    u_if.upd_pc     = v_pc[i];
    u_if.upd_taken  = v_tk[i];
    u_if.upd_target = v_tgt[i];
  endtask

  task automatic exp_vec(input int i);
    wr_t e;
    e.idx = v_idx[i]; e.valid = v_tk[i]; e.tag = v_tag[i]; e.tgt = v_tgt[i];
    exp_q.push_back(e);
  endtask

  task automatic exp_sweep(input int lo, input int hi);
    wr_t e;
    for (int k = lo; k <= hi; k++) begin
      e.idx = IL'(k); e.valid = 1'b0; e.tag = '0; e.tgt = '0;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every BTB write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t a, e;
    if (rst_n && btb_wr_en) begin
      a.idx = btb_wr_index; a.valid = btb_wr_valid; a.tag = btb_wr_tag; a.tgt = btb_wr_target;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL btb_write: got idx=%0h v=%0b tag=%0h tgt=%0h expected no write",
                 a.idx, a.valid, a.tag, a.tgt);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL btb_write: got idx=%0h v=%0b tag=%0h tgt=%0h expected idx=%0h v=%0b tag=%0h tgt=%0h",
                   a.idx, a.valid, a.tag, a.tgt, e.idx, e.valid, e.tag, e.tgt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, waits, ws, n;
    logic acc;
    v_pc[0] = 32'h0000_1234; v_tk[0] = 1'b1; v_tgt[0] = 32'h0000_2000; v_idx[0] = 4'h4; v_tag[0] = 28'h000_0123;
    v_pc[1] = 32'h8000_00F8; v_tk[1] = 1'b1; v_tgt[1] = 32'h8000_0100; v_idx[1] = 4'h8; v_tag[1] = 28'h800_000F;
    v_pc[2] = 32'h0000_0ABC; v_tk[2] = 1'b0; v_tgt[2] = 32'h0000_0AC0; v_idx[2] = 4'hC; v_tag[2] = 28'h000_00AB;
    v_pc[3] = 32'hDEAD_BEE1; v_tk[3] = 1'b1; v_tgt[3] = 32'h1000_0004; v_idx[3] = 4'h1; v_tag[3] = 28'hDEA_DBEE;
    v_pc[4] = 32'h1234_5677; v_tk[4] = 1'b0; v_tgt[4] = 32'h1234_567B; v_idx[4] = 4'h7; v_tag[4] = 28'h123_4567;
    v_pc[5] = 32'hFFFF_FFF0; v_tk[5] = 1'b1; v_tgt[5] = 32'h0000_0000; v_idx[5] = 4'h0; v_tag[5] = 28'hFFF_FFFF;
    v_pc[6] = 32'h0000_0045; v_tk[6] = 1'b1; v_tgt[6] = 32'h0000_0400; v_idx[6] = 4'h5; v_tag[6] = 28'h000_0004;
    v_pc[7] = 32'hCAFE_F00D; v_tk[7] = 1'b1; v_tgt[7] = 32'hCAFE_0000; v_idx[7] = 4'hD; v_tag[7] = 28'hCAF_EF00;

    rst_n = 1'b0; flush_req = 1'b0;
    u_if.upd_req = 1'b0; u_if.upd_pc = '0; u_if.upd_taken = 1'b0; u_if.upd_target = '0;
    #2;
    chk("rst_wr_en", btb_wr_en, 0);
    chk("rst_stall", u_if.upd_stall, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_lookup_block", lookup_block, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_wr_fields", {btb_wr_index, btb_wr_valid, btb_wr_tag, btb_wr_target}, 0);
    tick(); tick(); rst_n = 1'b1; tick();
    chk("idle_no_auto_sweep", flush_busy, 0);

    // Single taken update: written the cycle after acceptance.
    put_upd(0); chk("t1_stall", u_if.upd_stall, 0);
    tick(); exp_vec(0); u_if.upd_req = 1'b0;
    chk("t1_q_count_1", q_count, 1);
    chk("t1_wr_en", btb_wr_en, 1);
    tick(); chk("t1_q_count_0", q_count, 0);

    // Back-to-back updates drain at one per cycle without stalling.
    for (int i = 1; i <= 5; i++) begin
      put_upd(i); chk("t2_no_stall", u_if.upd_stall, 0);
      tick(); exp_vec(i);
    end
    u_if.upd_req = 1'b0;
    chk("t2_q_count_1", q_count, 1);
    tick(); chk("t2_q_count_0", q_count, 0);

    // Flush in IDLE: same-edge update discarded, 16 sweep writes, then DONE pulse.
    put_upd(6); flush_req = 1'b1;
    tick(); flush_req = 1'b0; u_if.upd_req = 1'b0; exp_sweep(0, 15);
    chk("t3_q_count", q_count, 0);
    chk("t3_busy", flush_busy, 1);
    lb = 0;
    for (int c = 0; c < 16; c++) begin
      if (lookup_block) lb++;
      tick();
    end
    chk("t3_lookup_cycles", lb, 16);
    chk("t3_done_pulse", flush_done, 1);
    chk("t3_done_no_block", lookup_block, 0);
    chk("t3_done_no_write", btb_wr_en, 0);
    tick();
    chk("t3_done_cleared", flush_done, 0);
    chk("t3_idle_not_busy", flush_busy, 0);
    chk("t3_no_stale_write", btb_wr_en, 0);

    // Updates during sweep are held until DONE; 5th stalls until a slot frees.
    flush_req = 1'b1; tick(); flush_req = 1'b0; exp_sweep(0, 15);
    for (int i = 0; i < 4; i++) begin
      put_upd(i); tick(); exp_vec(i);
    end
    u_if.upd_req = 1'b0;
    chk("t4_q_count_full", q_count, 4);
    chk("t4_stall", u_if.upd_stall, 1);
    put_upd(4); waits = 0; acc = 1'b0;
    while (waits <= 64) begin
      @(negedge clk); acc = !u_if.upd_stall;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
    end
    u_if.upd_req = 1'b0;
    if (acc) exp_vec(4);
    chk("t4_stall_cycles", waits, 14);
    for (int c = 0; c < 5; c++) tick();
    chk("t4_drained", q_count, 0);

    // Restart at sweep index 9: 10 + 16 writes before flush_done.
    flush_req = 1'b1; tick(); flush_req = 1'b0; exp_sweep(0, 9);
    ws = 0;
    for (int k = 0; k < 10; k++) begin
      if (btb_wr_en) ws++;
      if (k == 9) flush_req = 1'b1;
      tick();
    end
    flush_req = 1'b0; exp_sweep(0, 15);
    n = 0;
    while (!flush_done && n < 64) begin
      if (btb_wr_en) ws++;
      tick(); n++;
    end
    chk("t5_sweep_writes", ws, 26);
    chk("t5_done_seen", flush_done, 1);
    tick();

    // Asynchronous reset mid-sweep with one queued update.
    flush_req = 1'b1; tick(); flush_req = 1'b0; exp_sweep(0, 3);
    put_upd(5); tick(); u_if.upd_req = 1'b0;
    tick(); tick(); tick();
    #1; rst_n = 1'b0; #1;
    chk("t6_wr_en", btb_wr_en, 0);
    chk("t6_lookup_block", lookup_block, 0);
    chk("t6_busy", flush_busy, 0);
    chk("t6_q_count", q_count, 0);
    chk("t6_wr_index", btb_wr_index, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    chk("t6_idle_busy", flush_busy, 0);
    chk("t6_idle_wr_en", btb_wr_en, 0);
    tick();
    chk("t6_no_resume", btb_wr_en, 0);

    put_upd(7); tick(); exp_vec(7); u_if.upd_req = 1'b0;
    chk("post_rst_wr_en", btb_wr_en, 1);
    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
